// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide engine and the ALU ops that read its Hi/Lo pair.
package muldiv_pkg;

    localparam logic [4:0] OP_MULT = 5'd6;
    localparam logic [4:0] OP_DIV  = 5'd7;
    localparam logic [4:0] OP_MFLO = 5'd8;
    localparam logic [4:0] OP_MFHI = 5'd9;

    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold WIDTH itself once the last iteration has been counted.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide, purely combinational.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   shreg,
    input  logic [WIDTH-1:0]   operand,
    input  logic [4:0]         op,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0]   shreg_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    // Multiply: acc upper half is the running partial product, the carry shifts back in.
    // Divide: acc upper half is the remainder, lower half collects quotient bits.
    always_comb begin
        sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (shreg[0] ? operand : WIDTH'(0))};
        rem_sh     = {acc[2*WIDTH-1:WIDTH], shreg[WIDTH-1]};
        diff       = rem_sh[WIDTH-1:0] - operand;
        acc_next   = {sum, acc[WIDTH-1:1]};
        shreg_next = {1'b0, shreg[WIDTH-1:1]};
        if (op == OP_DIV) begin
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
            // A zero divisor always subtracts, giving all-ones quotient and dividend remainder.
            if (rem_sh >= {1'b0, operand}) begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide producing the Hi/Lo pair; one iteration per cycle, WIDTH cycles per op.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t             state_q;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   shreg_next;
    logic [WIDTH-1:0]   operand_q;
    logic [4:0]         op_q;
    logic               accept_c;
    logic               last_c;

    assign accept_c = (state_q == IDLE) && start && ((op == OP_MULT) || (op == OP_DIV));
    assign last_c   = (cnt_q == CNT_W'(WIDTH - 1));
    assign rd_data  = rd_sel ? hi : lo;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc        (acc_q),
        .shreg      (shreg_q),
        .operand    (operand_q),
        .op         (op_q),
        .acc_next   (acc_next),
        .shreg_next (shreg_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_n = BUSY;
            BUSY:    if (last_c) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Status flags track the state being entered so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_n != IDLE);
            done <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            shreg_q   <= '0;
            operand_q <= '0;
            op_q      <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        op_q  <= op;
                        acc_q <= '0;
                        cnt_q <= '0;
                        // shreg carries the bits consumed serially: multiplier or dividend.
                        if (op == OP_DIV) begin
                            operand_q <= b;
                            shreg_q   <= a;
                        end else begin
                            operand_q <= a;
                            shreg_q   <= b;
                        end
                    end
                end
                BUSY: begin
                    acc_q   <= acc_next;
                    shreg_q <= shreg_next;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_c) begin
                        hi <= acc_next[2*WIDTH-1:WIDTH];
                        lo <= acc_next[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  op = 5'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        rd_sel = 1'b0;
    logic [31:0] rd_data;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .rd_sel  (rd_sel),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic, divide-by-zero yields all-ones / dividend.
    task automatic model(input logic [31:0] ta, input logic [31:0] tb_v, input logic [4:0] top,
                         output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        if (top == OP_MULT) begin
            p  = {32'd0, ta} * {32'd0, tb_v};
            eh = p[63:32];
            el = p[31:0];
        end else if (tb_v == 32'd0) begin
            eh = ta;
            el = 32'hFFFF_FFFF;
        end else begin
            eh = ta % tb_v;
            el = ta / tb_v;
        end
    endtask

    // Issue one request and follow it to completion; inj > 0 pulses an extra divide start before that edge.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [4:0] top, input int inj);
        logic [31:0] eh, el;
        int dn_edge, busy_n, dc0;
        model(ta, tb_v, top, eh, el);
        @(negedge clk);
        a = ta; b = tb_v; op = top; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom;
        dc0 = done_cnt;
        busy_n = busy ? 1 : 0;
        dn_edge = -1;
        for (int k = 1; k <= 40 && busy === 1'b1; k++) begin
            if (k == inj) begin start = 1'b1; op = OP_DIV; end
            if (k == 5) begin
                rd_sel = 1'b0;
                #1 chk({tag, "_rd_during_busy"}, rd_data, m_lo);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1 && dn_edge < 0) dn_edge = k;
        end
        chk({tag, "_done_edge"}, dn_edge, 32);
        chk({tag, "_busy_cycles"}, busy_n, 33);
        chk({tag, "_done_pulses"}, done_cnt - dc0, 1);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        rd_sel = 1'b1;
        #1 chk({tag, "_rd_hi"}, rd_data, eh);
        rd_sel = 1'b0;
        #1 chk({tag, "_rd_lo"}, rd_data, el);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        int dc0;
        int guard;
        logic [31:0] ra, rb;
        logic [4:0] rop;

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_rd", rd_data, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_12x4", 32'd12, 32'd4, OP_MULT, 0);
        run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULT, 0);
        run_op("div_13_4", 32'd13, 32'd4, OP_DIV, 0);
        run_op("div_by_0", 32'd7, 32'd0, OP_DIV, 0);

        // Extra start during BUSY must be ignored, then a non-mul/div op while IDLE too.
        run_op("mul_inj", 32'd12, 32'd4, OP_MULT, 10);
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1; op = OP_MFLO; a = $urandom; b = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk("op8_busy", busy, 0);
        start = 1'b0;
        repeat (36) @(posedge clk);
        #1;
        chk("op8_hi", hi, 32'd0);
        chk("op8_lo", lo, 32'd48);
        chk("op8_no_done", done_cnt - dc0, 0);

        // Holding start high: no accept on E33 (DONE), re-accept on E34.
        @(negedge clk);
        a = 32'd12; b = 32'd4; op = OP_MULT; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            if (k == 33) chk("hold_gap_busy", busy, 0);
            if (k == 34) chk("hold_reaccept_busy", busy, 1);
        end
        start = 1'b0;
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("hold_finish_busy", busy, 0);
        chk("hold_lo", lo, 32'd48);
        chk("hold_hi", hi, 32'd0);

        // Reset mid-operation aborts and clears Hi/Lo.
        run_op("div_pre_rst", 32'd13, 32'd4, OP_DIV, 0);
        @(negedge clk);
        a = 32'd12; b = 32'd4; op = OP_MULT; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        dc0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - dc0, 0);
        chk("abort_idle_busy", busy, 0);
        chk("abort_hold_lo", lo, 0);
        run_op("mul_after_rst", 32'd12, 32'd4, OP_MULT, 0);

        for (int i = 0; i < 24; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), ra, rb, rop, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
